// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline memory-port controller:
// FSM state encoding, stall vector width, stall bit indices and stall patterns.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_RD  = 2'd1,
    MEM_RD = 2'd2,
    MEM_WR = 2'd3
  } state_e;

  localparam int unsigned StallSignalLen = 6;

  localparam int unsigned StallPc  = 0;
  localparam int unsigned StallIf  = 1;
  localparam int unsigned StallId  = 2;
  localparam int unsigned StallEx  = 3;
  localparam int unsigned StallMem = 4;
  localparam int unsigned StallWb  = 5;

  // Stalling a stage also stalls every stage in front of it.
  function automatic logic [StallSignalLen-1:0] stall_upto(input int unsigned idx);
    logic [StallSignalLen-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < StallSignalLen; i++) begin
      if (i <= idx) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [StallSignalLen-1:0] StallMemPat = stall_upto(StallMem);
  localparam logic [StallSignalLen-1:0] StallLdPat  = stall_upto(StallId);
  localparam logic [StallSignalLen-1:0] StallIfPat  = stall_upto(StallIf);

endpackage

// File: rtl/pipe_ctrl_stall_gen.sv
// Combinational per-stage stall vector; a pending load/store outranks a
// load-use hazard, which outranks a pending fetch. Forced to zero in reset.
module stall_gen
  import pipe_ctrl_pkg::*;
(
  input  logic                      rst,
  input  logic                      mem_req,
  input  logic                      mem_done,
  input  logic                      ld_use,
  input  logic                      if_req,
  input  logic                      if_done,
  output logic [StallSignalLen-1:0] stall_signal
);

  always_comb begin
    stall_signal = '0;
    if (rst)                        stall_signal = '0;
    else if (mem_req && !mem_done)  stall_signal = StallMemPat;
    else if (ld_use)                stall_signal = StallLdPat;
    else if (if_req && !if_done)    stall_signal = StallIfPat;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Arbitrates fetch and load/store onto one byte-wide RAM port, byte-serial.
// Optional STALL_CNT_EN adds a free-running stall-cycle counter output.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [31:0]               if_addr,
  input  logic                      mem_req,
  input  logic                      mem_we,
  input  logic [1:0]                mem_len,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  input  logic                      ld_use,
  input  logic                      jump_flag,
  input  logic [7:0]                ram_din,
  output logic [31:0]               ram_a,
  output logic [7:0]                ram_dout,
  output logic                      ram_wr,
  output logic                      if_done,
  output logic [31:0]               if_data,
  output logic                      mem_done,
  output logic [31:0]               mem_rdata,
  output logic [StallSignalLen-1:0] stall_signal
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt
`endif
);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] asm_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  len_q;

  logic [2:0]  last_idx;
  logic [2:0]  rd_last;
  logic [31:0] merged;
  logic        is_rd;

  assign last_idx = {1'b0, len_q};
  assign rd_last  = last_idx + 3'd1;
  assign is_rd    = (state_q == IF_RD) || (state_q == MEM_RD);

  // RAM data lags its address by one cycle, so byte cnt-1 arrives at count cnt.
  always_comb begin
    merged = asm_q;
    case (cnt_q)
      3'd1:    merged[7:0]   = ram_din;
      3'd2:    merged[15:8]  = ram_din;
      3'd3:    merged[23:16] = ram_din;
      3'd4:    merged[31:24] = ram_din;
      default: merged = asm_q;
    endcase
  end

  always_comb begin
    ram_a    = '0;
    ram_dout = '0;
    ram_wr   = 1'b0;
    if (is_rd && (cnt_q <= last_idx)) begin
      ram_a = addr_q + {29'd0, cnt_q};
    end else if (state_q == MEM_WR) begin
      ram_a  = addr_q + {29'd0, cnt_q};
      ram_wr = 1'b1;
      case (cnt_q[1:0])
        2'd0:    ram_dout = wdata_q[7:0];
        2'd1:    ram_dout = wdata_q[15:8];
        2'd2:    ram_dout = wdata_q[23:16];
        default: ram_dout = wdata_q[31:24];
      endcase
    end
  end

  assign if_done   = (state_q == IF_RD) && (cnt_q == rd_last) && !jump_flag;
  assign if_data   = if_done ? merged : '0;
  assign mem_done  = ((state_q == MEM_RD) && (cnt_q == rd_last)) ||
                     ((state_q == MEM_WR) && (cnt_q == last_idx));
  assign mem_rdata = (state_q == MEM_RD && mem_done) ? merged : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          asm_q <= '0;
          if (mem_req) begin
            state_q <= mem_we ? MEM_WR : MEM_RD;
            addr_q  <= mem_addr;
            len_q   <= mem_len;
            wdata_q <= mem_wdata;
          end else if (if_req) begin
            state_q <= IF_RD;
            addr_q  <= if_addr;
            len_q   <= 2'd3;
          end
        end
        IF_RD, MEM_RD: begin
          if ((state_q == IF_RD && jump_flag) || cnt_q == rd_last) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            asm_q <= merged;
          end
        end
        MEM_WR: begin
          if (cnt_q == last_idx) state_q <= IDLE;
          else                   cnt_q   <= cnt_q + 3'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  stall_gen u_stall_gen (
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_done     (mem_done),
    .ld_use       (ld_use),
    .if_req       (if_req),
    .if_done      (if_done),
    .stall_signal (stall_signal)
  );

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  assign stall_cnt_d = stall_cnt_q + 32'd1;
  assign stall_cnt   = stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                stall_cnt_q <= '0;
    else if (|stall_signal) stall_cnt_q <= stall_cnt_d;
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a byte-wide RAM model (one-cycle read latency).
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, ld_use, jump_flag;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic [7:0]  ram_din;
  logic [31:0] ram_a, if_data, mem_rdata;
  logic [7:0]  ram_dout;
  logic        ram_wr, if_done, mem_done;
  logic [StallSignalLen-1:0] stall_signal;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] ram [0:4095];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_din <= ram[ram_a[11:0]];
    if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
  end

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_len      (mem_len),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .ld_use       (ld_use),
    .jump_flag    (jump_flag),
    .ram_din      (ram_din),
    .ram_a        (ram_a),
    .ram_dout     (ram_dout),
    .ram_wr       (ram_wr),
    .if_done      (if_done),
    .if_data      (if_data),
    .mem_done     (mem_done),
    .mem_rdata    (mem_rdata),
    .stall_signal (stall_signal)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Waits up to 12 cycles for if_done; reports cycles waited and the word.
  task automatic wait_if(output logic got, output int cyc, output logic [31:0] data);
    got  = 1'b0;
    cyc  = 0;
    data = '0;
    for (int k = 1; k <= 12 && !got; k++) begin
      @(negedge clk);
      if (if_done) begin
        got  = 1'b1;
        cyc  = k;
        data = if_data;
      end
    end
  endtask

  logic        got;
  int          cyc;
  logic [31:0] data;
  logic        seen;

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13;
    ram[12'h020] = 8'hFF;
    ram[12'h300] = 8'h78; ram[12'h301] = 8'h56;
    ram[12'h302] = 8'h34; ram[12'h303] = 8'h12;
    ram_din   = 8'h00;
    rst       = 1'b1;
    if_req    = 1'b1;
    mem_req   = 1'b1;
    mem_we    = 1'b0;
    mem_len   = 2'd0;
    if_addr   = 32'h0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    ld_use    = 1'b1;
    jump_flag = 1'b0;

    // Reset: outputs held at zero even with requests pending.
    repeat (2) @(negedge clk);
    chk("rst_stall", {26'd0, stall_signal}, 32'h0);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'h0);
    chk("rst_dones", {30'd0, if_done, mem_done}, 32'h0);
    drive_edge();
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; ld_use = 1'b0;

    // Fetch 0x100: bytes 13,00,00,00, done in cycle 5.
    drive_edge();
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("if0_stall", {26'd0, stall_signal}, 32'h03);
    chk("if0_ram_a", ram_a, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k < 5) begin
        chk($sformatf("if%0d_ram_a", k), ram_a, 32'h100 + k - 1);
        chk($sformatf("if%0d_done", k), {31'd0, if_done}, 32'h0);
      end else begin
        chk("if5_done", {31'd0, if_done}, 32'h1);
        chk("if5_data", if_data, 32'h00000013);
        chk("if5_stall", {26'd0, stall_signal}, 32'h0);
      end
    end
    drive_edge();
    if_req = 1'b0;
    @(negedge clk);
    chk("if_idle_ram_a", ram_a, 32'h0);

    // Simultaneous load (len 0 @0x20) and fetch: load first.
    drive_edge();
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h20;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("arb0_stall", {26'd0, stall_signal}, 32'h1F);
    @(negedge clk);
    chk("arb1_ram_a", ram_a, 32'h20);
    chk("arb1_done", {31'd0, mem_done}, 32'h0);
    @(negedge clk);
    chk("arb2_done", {31'd0, mem_done}, 32'h1);
    chk("arb2_rdata", mem_rdata, 32'h000000FF);
    chk("arb2_stall", {26'd0, stall_signal}, 32'h03);
    drive_edge();
    mem_req = 1'b0;
    @(negedge clk);
    chk("arb3_ram_a", ram_a, 32'h0);
    @(negedge clk);
    chk("arb4_if_ram_a", ram_a, 32'h100);
    wait_if(got, cyc, data);
    chk("arb_if_done", {31'd0, got}, 32'h1);
    chk("arb_if_cyc", cyc, 32'd4);
    chk("arb_if_data", data, 32'h00000013);
    drive_edge();
    if_req = 1'b0;

    // Store len 3 of 0xAABBCCDD at 0x40.
    drive_edge();
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h40;
    mem_wdata = 32'hAABBCCDD;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("st%0d_wr", k), {31'd0, ram_wr}, 32'h1);
      chk($sformatf("st%0d_a", k), ram_a, 32'h40 + k - 1);
      chk($sformatf("st%0d_dout", k), {24'd0, ram_dout}, 32'(8'hDD - 8'h11 * (k - 1)));
      chk($sformatf("st%0d_done", k), {31'd0, mem_done}, {31'd0, k == 4});
    end
    drive_edge();
    mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
    chk("st_idle_wr", {31'd0, ram_wr}, 32'h0);
    chk("st_ram40", {24'd0, ram[12'h040]}, 32'hDD);
    chk("st_ram43", {24'd0, ram[12'h043]}, 32'hAA);

    // Jump at cnt 2 aborts the fetch; a new fetch is then accepted.
    drive_edge();
    if_req = 1'b1; if_addr = 32'h200;
    @(negedge clk);
    @(negedge clk);
    chk("jmp1_ram_a", ram_a, 32'h200);
    @(negedge clk);
    drive_edge();
    jump_flag = 1'b1;
    @(negedge clk);
    chk("jmp3_ram_a", ram_a, 32'h202);
    chk("jmp3_stall", {26'd0, stall_signal}, 32'h03);
    chk("jmp3_done", {31'd0, if_done}, 32'h0);
    drive_edge();
    jump_flag = 1'b0; if_addr = 32'h300;
    @(negedge clk);
    chk("jmp4_ram_a", ram_a, 32'h0);
    chk("jmp4_done", {31'd0, if_done}, 32'h0);
    @(negedge clk);
    chk("jmp5_ram_a", ram_a, 32'h300);
    wait_if(got, cyc, data);
    chk("jmp_if_done", {31'd0, got}, 32'h1);
    chk("jmp_if_cyc", cyc, 32'd4);
    chk("jmp_if_data", data, 32'h12345678);
    drive_edge();
    if_req = 1'b0;

    // Load-use with the port idle, then with a pending load.
    drive_edge();
    ld_use = 1'b1;
    @(negedge clk);
    chk("ld_stall", {26'd0, stall_signal}, 32'h07);
    drive_edge();
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h20;
    @(negedge clk);
    chk("ldmem_stall", {26'd0, stall_signal}, 32'h1F);
    @(negedge clk);
    @(negedge clk);
    chk("ldmem_done", {31'd0, mem_done}, 32'h1);
    chk("ldmem_done_stall", {26'd0, stall_signal}, 32'h07);
    drive_edge();
    mem_req = 1'b0; ld_use = 1'b0;

    // Reset during store cnt 1 abandons it.
    drive_edge();
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h50;
    mem_wdata = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rs_pre_a", ram_a, 32'h51);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_wr", {31'd0, ram_wr}, 32'h0);
    chk("rs_a", ram_a, 32'h0);
    chk("rs_stall", {26'd0, stall_signal}, 32'h0);
    drive_edge();
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_done || ram_wr) seen = 1'b1;
    end
    chk("rs_no_activity", {31'd0, seen}, 32'h0);
    chk("rs_ram50", {24'd0, ram[12'h050]}, 32'h44);
    chk("rs_ram51", {24'd0, ram[12'h051]}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
